// File: rtl/char_pkg.sv
// Shared types and helpers for the cell characterisation sweep sequencer
// and the readback/Liberty-writer logic that consumes its result memory.
package char_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        DRIVE,
        WAIT,
        MEAS,
        WRITE,
        DONE
    } state_t;

    // Written in place of a measurement that never arrived; sliced to MEAS_W at use.
    localparam int SENTINEL_W = 64;
    localparam logic [SENTINEL_W-1:0] SENTINEL = '1;

    // Liberty table order: slope outermost, then capa, pin, edge (0 = away, 1 = return).
    function automatic int unsigned addr_calc(
        input int unsigned slope,
        input int unsigned capa,
        input int unsigned pin,
        input int unsigned edg,
        input int unsigned n_capa,
        input int unsigned n_pins
    );
        return (((slope * n_capa) + capa) * n_pins + pin) * 2 + edg;
    endfunction

endpackage

// File: rtl/char_idx_counter.sv
// Nested slope/capa/pin/edge counters walking the characterisation grid,
// edge innermost, with wrap flags and the look-ahead of the next grid point.
module char_idx_counter
    import char_pkg::*;
#(
    parameter int N_SLOPES = 7,
    parameter int N_CAPA   = 7,
    parameter int N_PINS   = 2,
    parameter int SW       = 3,
    parameter int CW       = 3,
    parameter int PW       = 1
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          clr,
    input  logic          adv,
    output logic [SW-1:0] slope,
    output logic [CW-1:0] capa,
    output logic [PW-1:0] pin,
    output logic          edg,
    output logic [SW-1:0] nxt_slope,
    output logic [CW-1:0] nxt_capa,
    output logic          pin_last,
    output logic          grid_last
);

    logic slope_last;
    logic capa_last;
    logic pin_max;

    assign slope_last = (slope == SW'(N_SLOPES - 1));
    assign capa_last  = (capa == CW'(N_CAPA - 1));
    assign pin_max    = (pin == PW'(N_PINS - 1));
    assign pin_last   = edg && pin_max;
    assign grid_last  = pin_last && capa_last && slope_last;

    assign nxt_capa  = capa_last ? '0 : capa + CW'(1);
    assign nxt_slope = capa_last ? (slope_last ? '0 : slope + SW'(1)) : slope;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slope <= '0;
            capa  <= '0;
            pin   <= '0;
            edg   <= 1'b0;
        end else if (clr) begin
            slope <= '0;
            capa  <= '0;
            pin   <= '0;
            edg   <= 1'b0;
        end else if (adv) begin
            if (!edg) begin
                edg <= 1'b1;
            end else begin
                edg <= 1'b0;
                pin <= pin_max ? '0 : pin + PW'(1);
                if (pin_max) begin
                    capa  <= nxt_capa;
                    slope <= nxt_slope;
                end
            end
        end
    end

endmodule

// File: rtl/char_sweep_seq.sv
// Characterisation sequencer: walks the slope x load grid, toggles each cell
// input away from and back to rest, and records one measurement per edge.
module char_sweep_seq
    import char_pkg::*;
#(
    parameter int N_SLOPES = 7,
    parameter int N_CAPA   = 7,
    parameter int N_PINS   = 2,
    parameter int SETTLE   = 7,
    parameter int MEAS_W   = 32,
    parameter int TIMEOUT  = 1024,
    parameter int AW       = $clog2(N_SLOPES * N_CAPA * N_PINS * 2)
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        start,
    input  logic                        mode,
    output logic [$clog2(N_SLOPES)-1:0] slope_idx,
    output logic [$clog2(N_CAPA)-1:0]   capa_idx,
    output logic [N_PINS-1:0]           din,
    output logic                        meas_req,
    input  logic                        meas_valid,
    input  logic [MEAS_W-1:0]           meas_data,
    output logic                        wr_en,
    output logic [AW-1:0]               wr_addr,
    output logic [MEAS_W-1:0]           wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int SW    = $clog2(N_SLOPES);
    localparam int CW    = $clog2(N_CAPA);
    localparam int PW    = (N_PINS > 1) ? $clog2(N_PINS) : 1;
    localparam int T_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   cnt;
    logic            cnt_clr;
    logic            ctr_clr;
    logic            ctr_adv;
    logic            mode_q;
    logic [SW-1:0]   slope;
    logic [CW-1:0]   capa;
    logic [PW-1:0]   pin;
    logic            edg;
    logic [SW-1:0]   nxt_slope;
    logic [CW-1:0]   nxt_capa;
    logic            pin_last;
    logic            grid_last;
    logic            settle_done;
    logic            meas_to;
    logic [N_PINS-1:0] rest;
    logic [N_PINS-1:0] pin_mask;
    logic [N_PINS-1:0] drive_pat;

    char_idx_counter #(
        .N_SLOPES (N_SLOPES),
        .N_CAPA   (N_CAPA),
        .N_PINS   (N_PINS),
        .SW       (SW),
        .CW       (CW),
        .PW       (PW)
    ) u_idx (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (ctr_clr),
        .adv       (ctr_adv),
        .slope     (slope),
        .capa      (capa),
        .pin       (pin),
        .edg       (edg),
        .nxt_slope (nxt_slope),
        .nxt_capa  (nxt_capa),
        .pin_last  (pin_last),
        .grid_last (grid_last)
    );

    // One shared counter times CFG/WAIT settling and the MEAS timeout.
    assign settle_done = (cnt == TW'(SETTLE - 1));
    assign meas_to     = (cnt == TW'(TIMEOUT - 1));

    assign rest      = {N_PINS{~mode_q}};
    assign pin_mask  = N_PINS'(1) << pin;
    assign drive_pat = edg ? rest : (rest ^ pin_mask);

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b1;
        ctr_clr   = 1'b0;
        ctr_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CFG;
                    ctr_clr   = 1'b1;
                end
            end
            CFG: begin
                if (settle_done) state_nxt = DRIVE;
                else             cnt_clr   = 1'b0;
            end
            DRIVE: state_nxt = WAIT;
            WAIT: begin
                if (settle_done) state_nxt = MEAS;
                else             cnt_clr   = 1'b0;
            end
            MEAS: begin
                if (meas_valid || meas_to) state_nxt = WRITE;
                else                       cnt_clr   = 1'b0;
            end
            WRITE: begin
                ctr_adv = 1'b1;
                if (grid_last)     state_nxt = DONE;
                else if (pin_last) state_nxt = CFG;
                else               state_nxt = DRIVE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_clr ? '0 : cnt + TW'(1);
        end
    end

    // Index outputs only move on CFG entry so the config drivers see a stable point.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mode_q      <= 1'b0;
            din         <= '1;
            timeout_err <= 1'b0;
            wr_data     <= '0;
            slope_idx   <= '0;
            capa_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        din         <= {N_PINS{~mode}};
                        timeout_err <= 1'b0;
                        slope_idx   <= '0;
                        capa_idx    <= '0;
                    end
                end
                DRIVE: din <= drive_pat;
                MEAS: begin
                    if (meas_valid) begin
                        wr_data <= meas_data;
                    end else if (meas_to) begin
                        wr_data     <= SENTINEL[MEAS_W-1:0];
                        timeout_err <= 1'b1;
                    end
                end
                WRITE: begin
                    if (pin_last && !grid_last) begin
                        slope_idx <= nxt_slope;
                        capa_idx  <= nxt_capa;
                    end
                end
                default: ;
            endcase
        end
    end

    assign meas_req = (state == MEAS);
    assign wr_en    = (state == WRITE);
    assign busy     = (state inside {CFG, DRIVE, WAIT, MEAS, WRITE});
    assign done     = (state == DONE);
    assign wr_addr  = wr_en ? AW'(addr_calc(32'(slope), 32'(capa), 32'(pin), 32'(edg),
                                            N_CAPA, N_PINS)) : '0;

endmodule

// File: tb/tb_char_sweep_seq.sv
// Randomised bench for char_sweep_seq on a 2x2 grid with two pins: a latency-
// randomised measurement responder plus a grid-order reference of writes and din edges.
module tb_char_sweep_seq;

    localparam int NS = 2;
    localparam int NC = 2;
    localparam int NP = 2;
    localparam int ST = 3;
    localparam int TO = 8;
    localparam int MW = 32;
    localparam int AWD = 4;
    localparam int NW = NS * NC * NP * 2;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          meas_valid = 1'b0;
    logic [MW-1:0] meas_data = '0;
    logic [0:0]    slope_idx;
    logic [0:0]    capa_idx;
    logic [NP-1:0] din;
    logic          meas_req;
    logic          wr_en;
    logic [AWD-1:0] wr_addr;
    logic [MW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          timeout_err;

    always #5 clk = ~clk;

    char_sweep_seq #(
        .N_SLOPES (NS),
        .N_CAPA   (NC),
        .N_PINS   (NP),
        .SETTLE   (ST),
        .MEAS_W   (MW),
        .TIMEOUT  (TO),
        .AW       (AWD)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .mode        (mode),
        .slope_idx   (slope_idx),
        .capa_idx    (capa_idx),
        .din         (din),
        .meas_req    (meas_req),
        .meas_valid  (meas_valid),
        .meas_data   (meas_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Latency per request (0 = never answer); answer data is 0x100 + request number.
    int lat_tbl [NW];
    bit noise = 1'b0;
    int sweep_no = 0;
    int k = 0;
    int req_idx = 0;
    int cur_l = 0;

    always @(negedge clk) begin
        if (!nrst || !busy) begin
            k = 0;
            req_idx = 0;
            meas_valid = noise && ($urandom_range(0, 3) == 0);
            meas_data = $urandom;
        end else if (meas_req) begin
            if (k == 0) cur_l = (req_idx < NW) ? lat_tbl[req_idx] : 1;
            k++;
            if (cur_l != 0 && k == cur_l) begin
                meas_valid = 1'b1;
                meas_data = 32'(32'h100 + req_idx);
            end else begin
                meas_valid = 1'b0;
                meas_data = $urandom;
            end
        end else begin
            if (k != 0) req_idx++;
            k = 0;
            meas_valid = noise && ($urandom_range(0, 3) == 0);
            meas_data = $urandom;
        end
    end

    logic [AWD-1:0] wa_q [$];
    logic [MW-1:0]  wd_q [$];
    logic [1:0]     wi_q [$];
    logic [1:0]     din_q [$];
    logic [1:0]     idx_q [$];
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_gap = -1;
    int last_wr_tick = -100;
    int tick = 0;
    int seen_no = 0;
    logic [1:0] prev_din = '0;
    logic [1:0] prev_idx = '0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (sweep_no != seen_no) begin
            seen_no = sweep_no;
            wa_q.delete(); wd_q.delete(); wi_q.delete();
            din_q.delete(); idx_q.delete();
            busy_cnt = 0; done_cnt = 0; done_gap = -1; last_wr_tick = -100;
        end
        if (busy) busy_cnt++;
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wi_q.push_back({slope_idx, capa_idx});
            last_wr_tick = tick;
        end
        if (done) begin
            done_cnt++;
            done_gap = tick - last_wr_tick;
        end
        if (busy && (!prev_busy || din != prev_din)) din_q.push_back(din);
        if (busy && (!prev_busy || {slope_idx, capa_idx} != prev_idx))
            idx_q.push_back({slope_idx, capa_idx});
        prev_din = din;
        prev_busy = busy;
        prev_idx = {slope_idx, capa_idx};
        tick++;
    end

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_din"}, din, 2'b11);
        chk({pfx, "_slope"}, slope_idx, 0);
        chk({pfx, "_capa"}, capa_idx, 0);
        chk({pfx, "_req"}, meas_req, 0);
        chk({pfx, "_wr_en"}, wr_en, 0);
        chk({pfx, "_wr_addr"}, wr_addr, 0);
        chk({pfx, "_wr_data"}, wr_data, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_terr"}, timeout_err, 0);
    endtask

    task automatic run_sweep(input bit md, input int to_idx, input bit ns, input bit mid_start);
        int exp_cyc;
        bit got_done;
        logic [1:0] rest;
        logic [1:0] exp_din [$];
        logic [1:0] exp_idx [$];
        logic [MW-1:0] ed;
        int s;
        int c;
        noise = ns;
        rest = md ? 2'b00 : 2'b11;
        exp_cyc = NS * NC * ST;
        for (int i = 0; i < NW; i++) begin
            lat_tbl[i] = (i == to_idx) ? 0 : int'($urandom_range(1, 4));
            exp_cyc += 2 + ST + ((i == to_idx) ? TO : lat_tbl[i]);
        end
        sweep_no++;
        @(negedge clk);
        mode = md;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~md;
        chk("busy_rise", busy, 1);
        chk("err_clr", timeout_err, 0);
        got_done = 1'b0;
        for (int n = 0; n < 4000 && !got_done; n++) begin
            @(negedge clk);
            start = (mid_start && (n == 25 || n == 60));
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        @(negedge clk);
        @(negedge clk);

        chk("n_writes", wa_q.size(), NW);
        for (int i = 0; i < NW && i < wa_q.size(); i++) begin
            ed = (lat_tbl[i] == 0) ? 32'hFFFF_FFFF : 32'(32'h100 + i);
            s = i / (NC * NP * 2);
            c = (i / (NP * 2)) % NC;
            chk($sformatf("wr_addr[%0d]", i), wa_q[i], i);
            chk($sformatf("wr_data[%0d]", i), wd_q[i], ed);
            chk($sformatf("wr_idx[%0d]", i), wi_q[i], s * 2 + c);
        end

        exp_din.push_back(rest);
        for (int g = 0; g < NS * NC; g++) begin
            for (int p = 0; p < NP; p++) begin
                exp_din.push_back(rest ^ (2'b01 << p));
                exp_din.push_back(rest);
            end
        end
        chk("din_len", din_q.size(), exp_din.size());
        for (int i = 0; i < exp_din.size() && i < din_q.size(); i++)
            chk($sformatf("din[%0d]", i), din_q[i], exp_din[i]);

        for (int si = 0; si < NS; si++)
            for (int ci = 0; ci < NC; ci++)
                exp_idx.push_back(2'(si * 2 + ci));
        chk("idx_len", idx_q.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < idx_q.size(); i++)
            chk($sformatf("idx[%0d]", i), idx_q[i], exp_idx[i]);

        chk("busy_cycles", busy_cnt, exp_cyc);
        chk("done_gap", done_gap, 1);
        chk("done_width", done_cnt, 1);
        chk("timeout_err", timeout_err, (to_idx >= 0) ? 1 : 0);
        chk("busy_end", busy, 0);
        chk("din_idle", din, rest);
    endtask

    initial begin
        bit hit;
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        nrst = 1'b1;
        @(negedge clk);

        run_sweep(1'b0, -1, 1'b0, 1'b0);
        run_sweep(1'b1, -1, 1'b1, 1'b1);
        run_sweep(1'b1, 4, 1'b0, 1'b0);
        run_sweep(1'($urandom_range(0, 1)), -1, 1'b1, 1'b0);

        // Reset while the measurement for address 6 is pending.
        for (int i = 0; i < NW; i++) lat_tbl[i] = 2;
        noise = 1'b0;
        sweep_no++;
        @(negedge clk);
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            @(negedge clk);
            if (meas_req && req_idx == 6) hit = 1'b1;
        end
        chk("rst_reach", hit, 1);
        #2 nrst = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge clk);
        chk("arst_n_wr", wa_q.size(), 6);
        chk("arst_wr_en", wr_en, 0);
        nrst = 1'b1;
        @(negedge clk);
        run_sweep(1'b0, -1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/char_sweep_seq.md
# char_sweep_seq

Synthesizable characterisation sequencer for multi-input standard cells. It sweeps every (input slope, load capacitance) point of a parametrised N_SLOPES × N_CAPA grid and toggles each of N_PINS cell inputs away from and back to its non-controlling rest level. After each edge it handshakes with an external measurement unit and writes the result into a linear result memory in Liberty table order. It sits between the bench/analog configuration drivers (which consume slope_idx/capa_idx) and the energy/delay measurement block.

## Interface
- N_SLOPES, 7, number of input-slope grid points
- N_CAPA, 7, number of load-capacitance grid points
- N_PINS, 2, number of cell inputs swept
- SETTLE, 7, idle cycles after any configuration or pin change before measuring (≥1)
- MEAS_W, 32, measurement word width
- TIMEOUT, 1024, max cycles meas_req may wait for meas_valid
- AW, $clog2(N_SLOPES*N_CAPA*N_PINS*2), result address width

Ports:
- clk  in  1  single clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins sweep when idle
- mode  in  1  rest level of inputs: 0 → rest high (AND/NAND), 1 → rest low (OR/NOR); sampled at start
- slope_idx  out  $clog2(N_SLOPES)  current slope point
- capa_idx  out  $clog2(N_CAPA)  current load point
- din  out  N_PINS  cell input drive
- meas_req  out  1  measurement request, level
- meas_valid  in  1  measurement ready
- meas_data  in  MEAS_W  measurement value
- wr_en  out  1  result write strobe
- wr_addr  out  AW  result address
- wr_data  out  MEAS_W  result value
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- timeout_err  out  1  sticky, set on any measurement timeout, cleared by start

## Operation
- Reset: all outputs 0, except din = all-ones (mode unknown; rest-high default); state IDLE.
- IDLE: din = rest level of the last latched mode. start → latch mode, clear timeout_err, slope=capa=pin=edge=0, busy=1, → CFG.
- CFG: slope_idx/capa_idx presented; wait SETTLE cycles → DRIVE.
- DRIVE (1 cycle): din[pin] ← ~rest on edge 0, rest on edge 1; other pins held at rest → WAIT.
- WAIT: SETTLE cycles → MEAS.
- MEAS: meas_req=1 until meas_valid sampled high; capture meas_data → WRITE. If TIMEOUT cycles elapse first: capture all-ones sentinel, set timeout_err → WRITE.
- WRITE (1 cycle): wr_en=1, wr_addr = (((slope*N_CAPA)+capa)*N_PINS+pin)*2+edge, where edge 0 = away-from-rest and edge 1 = return. Then advance edge → pin → capa → slope, with the innermost index advancing first. When edge wraps, go to DRIVE with the next pin. When pin wraps, go to CFG with the new capa/slope. When the whole grid is exhausted → DONE.
- DONE (1 cycle): done=1, busy=0 → IDLE.
- start while busy: ignored. mode change while busy: ignored.
- meas_valid outside MEAS: ignored.
- Reset mid-sweep: immediate return to reset values; no partial write completes.

## Timing
- Per measurement, with meas_valid returning L cycles after meas_req rises (L ≥ 1): 1 (DRIVE) + SETTLE + L + 1 (WRITE) cycles.
- Per grid point: add SETTLE cycles of CFG.
- meas_req deasserts the cycle after meas_valid is sampled.
- wr_en is asserted in the cycle after that sample.
- busy rises the cycle after start.
- done rises the cycle after the last wr_en.
- Index outputs are registered. They change only on the CFG entry edge.

## Structure
- Package char_pkg holds the state enum (IDLE, CFG, DRIVE, WAIT, MEAS, WRITE, DONE), the sentinel constant, and an addr_calc function shared with the readback/Liberty-writer logic.
- A natural sub-module is char_idx_counter: nested slope/capa/pin/edge counters with wrap flags. The FSM and the settle/timeout counter stay in char_sweep_seq.

## Test plan
- N_SLOPES=2, N_CAPA=2, N_PINS=2, SETTLE=3, mode=0, meas model returns 0x100+req count with L=2 → 16 writes, addresses 0..15 in order, data 0x100..0x10F; done 1 cycle after the final write; total cycles match the Timing formula.
- Same configuration, observe din → din goes 2'b10, 2'b11, 2'b01, 2'b11 per grid point; index outputs change only at CFG.
- mode=1 → rest din=2'b00; edge-0 patterns 2'b01 and 2'b10.
- TIMEOUT=8, model never answers the 5th request → address 4 receives 0xFFFFFFFF and timeout_err=1 stays set; sweep completes. A new start clears timeout_err.
- nrst low for 1 cycle during MEAS of address 6 → all outputs at reset values asynchronously; no wr_en. A subsequent start restarts at address 0.
- start pulsed again mid-sweep, and meas_valid pulsed during WAIT → no effect; write sequence identical to scenario 1.
